dr_adder_stage: RTL
===================

Name: dr_adder_stage

Overview:
- Parametrised, clocked successor to the single-bit dual-rail full adder.
- WIDTH-bit dual-rail (NULL/DATA) ripple adder wrapped in a registered NCL-style pipeline stage.
- Has completion detection on the input link, a four-phase ki/ko handshake and illegal-codeword detection.
- Sits between dual-rail pipeline registers in the datapath.
- Bit i of any dual-rail vector occupies [2i+1:2i]: rail 0 = false, rail 1 = true, 00 = NULL, 11 = illegal.

Parameters:
- WIDTH, 8, number of dual-rail data bits per operand (legal range 1..32).
- RAIL_NUM, 2, rails per bit; localparam, fixed.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-low
- en  input  1  stage enable; low freezes all state and outputs
- a  input  RAIL_NUM*WIDTH  dual-rail operand A
- b  input  RAIL_NUM*WIDTH  dual-rail operand B
- c_in  input  RAIL_NUM  dual-rail carry in
- ki  input  1  downstream request: 1 = ready for DATA, 0 = ready for NULL
- ko  output  1  upstream request: 1 = ready for DATA, 0 = ready for NULL
- s  output  RAIL_NUM*WIDTH  dual-rail sum
- c_out  output  RAIL_NUM  dual-rail carry out
- err  output  1  sticky illegal-codeword flag

Behaviour:
- Reset (rst=0 at a clk edge) has priority over en.
  - Resets to state NULL_OUT: s=all 00, c_out=00, ko=1, err=0.
  - Reset mid-handshake abandons the current wavefront.
- Completion terms:
  - in_data: every pair of a, b and c_in is 01 or 10.
  - in_null: every pair is 00.
  - A pair at 11 counts toward neither term.
- Two-state FSM, all outputs registered, updates only when en=1:
  - NULL_OUT (s/c_out NULL, ko=1): if in_data && ki=1, next edge registers the result and moves to DATA_OUT with ko=0. Otherwise hold.
  - DATA_OUT (s/c_out DATA, ko=0): if in_null && ki=0, next edge drives s/c_out to NULL and moves to NULL_OUT with ko=1. Otherwise hold. Output DATA stays stable even if inputs change or go partial.
- Latency: exactly 1 clk from the edge where the transition condition is first sampled true to the updated outputs.
- Arithmetic:
  - Decode the true rails to binary A, B, Cin.
  - {C, S} = A + B + Cin, WIDTH+1 bits, no saturation.
  - Re-encode each bit: 1 -> 10, 0 -> 01 (true rail high for 1). c_out encodes C.
  - Output codewords are always strictly NULL or DATA, never mixed or 11.
- Partial wavefront (some pairs DATA, some NULL): hold in the current state. No timeout.
- ki mismatch (inputs complete but ki in the wrong phase): hold until ki matches. Both conditions are sampled on the same edge.
- err:
  - Set on any edge with en=1 where any input pair is 11.
  - Stays set until reset. It does not otherwise change the FSM: a pair at 11 blocks completion.
- en=0: no state, output, ko or err update. Resumes from the frozen state when en returns to 1.
- Overflow wrap: e.g. WIDTH=8, 255+1+0 gives S=0, C=1.

Test Plan:
- Reset: WIDTH=4, rst=0 for 2 cycles with arbitrary inputs -> s=8'h00, c_out=2'b00, ko=1, err=0.
- Basic add: WIDTH=4, A=5, B=3, Cin=0, ki=1 -> one cycle later S=8 (s=8'b10_01_01_01), c_out=01, ko=0. Then inputs NULL, ki=0 -> next cycle s=0, c_out=00, ko=1.
- Carry wrap: A=15, B=1, Cin=1 -> S=1, C=1 (c_out=10). Then A=0, B=0, Cin=0 -> S=0, C=0 with all true rails low, all false rails high.
- Partial and ki gating:
  - One bit of b held NULL for 5 cycles -> outputs stay NULL, ko=1; completing it gives DATA 1 cycle later.
  - Complete DATA with ki=0 -> no transition until ki=1.
- Illegal codeword: a[1:0]=11 for one cycle -> err=1 and stays 1, no transition. Fix a[1:0] -> normal completion proceeds with err still 1.
- en and reset mid-op:
  - en=0 while DATA_OUT with in_null && ki=0 -> outputs frozen; en=1 -> NULL next cycle.
  - rst=0 in DATA_OUT -> NULL_OUT, ko=1, err cleared next edge.

Source files
------------

// File: rtl/dr_adder_stage.sv
// Dual-rail (NULL/DATA) WIDTH-bit ripple adder in a registered NCL-style stage
// with input completion detection, four-phase ki/ko handshake and sticky illegal-codeword flag.
module dr_adder_stage #(
    parameter int WIDTH = 8,
    localparam int RAIL_NUM = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [RAIL_NUM*WIDTH-1:0] a,
    input  logic [RAIL_NUM*WIDTH-1:0] b,
    input  logic [RAIL_NUM-1:0]       c_in,
    input  logic                      ki,
    output logic                      ko,
    output logic [RAIL_NUM*WIDTH-1:0] s,
    output logic [RAIL_NUM-1:0]       c_out,
    output logic                      err
);

    typedef enum logic {
        NULL_OUT = 1'b0,
        DATA_OUT = 1'b1
    } state_t;

    function automatic logic pair_is_data(input logic [1:0] p);
        return p[1] ^ p[0];
    endfunction

    function automatic logic pair_is_null(input logic [1:0] p);
        return ~(p[1] | p[0]);
    endfunction

    function automatic logic pair_is_illegal(input logic [1:0] p);
        return p[1] & p[0];
    endfunction

    function automatic logic [RAIL_NUM*WIDTH-1:0] dr_encode(input logic [WIDTH-1:0] v);
        logic [RAIL_NUM*WIDTH-1:0] r;
        r = {(RAIL_NUM*WIDTH){1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
        end
        return r;
    endfunction

    state_t                    state_r;
    state_t                    next_state_s;
    logic                      in_data_s;
    logic                      in_null_s;
    logic                      illegal_s;
    logic [WIDTH-1:0]          a_bin_s;
    logic [WIDTH-1:0]          b_bin_s;
    logic [WIDTH:0]            sum_s;
    logic [RAIL_NUM*WIDTH-1:0] s_r;
    logic [RAIL_NUM-1:0]       c_out_r;
    logic                      ko_r;
    logic                      err_r;
    logic [RAIL_NUM*WIDTH-1:0] s_next_s;
    logic [RAIL_NUM-1:0]       c_out_next_s;
    logic                      ko_next_s;
    logic                      err_next_s;

    // Completion detection, illegal-pair detection and true-rail decode of the input link.
    always_comb begin
        in_data_s = pair_is_data(c_in);
        in_null_s = pair_is_null(c_in);
        illegal_s = pair_is_illegal(c_in);
        a_bin_s   = {WIDTH{1'b0}};
        b_bin_s   = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            in_data_s  = in_data_s & pair_is_data(a[2*i +: 2]) & pair_is_data(b[2*i +: 2]);
            in_null_s  = in_null_s & pair_is_null(a[2*i +: 2]) & pair_is_null(b[2*i +: 2]);
            illegal_s  = illegal_s | pair_is_illegal(a[2*i +: 2]) | pair_is_illegal(b[2*i +: 2]);
            a_bin_s[i] = a[2*i+1];
            b_bin_s[i] = b[2*i+1];
        end
        sum_s = {1'b0, a_bin_s} + {1'b0, b_bin_s} + {{WIDTH{1'b0}}, c_in[1]};
    end

    // State register; reset wins over enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= NULL_OUT;
        end else if (en) begin
            state_r <= next_state_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Next-state logic: a wavefront advances only when complete and ki is in the matching phase.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            NULL_OUT: begin
                if (in_data_s && ki) begin
                    next_state_s = DATA_OUT;
                end else begin
                    next_state_s = NULL_OUT;
                end
            end
            DATA_OUT: begin
                if (in_null_s && !ki) begin
                    next_state_s = NULL_OUT;
                end else begin
                    next_state_s = DATA_OUT;
                end
            end
            default: next_state_s = NULL_OUT;
        endcase
    end

    // Next output values; held outputs keep DATA stable even when inputs go partial.
    always_comb begin
        s_next_s     = s_r;
        c_out_next_s = c_out_r;
        ko_next_s    = ko_r;
        err_next_s   = err_r | illegal_s;
        case (state_r)
            NULL_OUT: begin
                if (next_state_s == DATA_OUT) begin
                    s_next_s     = dr_encode(sum_s[WIDTH-1:0]);
                    c_out_next_s = sum_s[WIDTH] ? 2'b10 : 2'b01;
                    ko_next_s    = 1'b0;
                end else begin
                    s_next_s     = {(RAIL_NUM*WIDTH){1'b0}};
                    c_out_next_s = 2'b00;
                    ko_next_s    = 1'b1;
                end
            end
            DATA_OUT: begin
                if (next_state_s == NULL_OUT) begin
                    s_next_s     = {(RAIL_NUM*WIDTH){1'b0}};
                    c_out_next_s = 2'b00;
                    ko_next_s    = 1'b1;
                end else begin
                    s_next_s     = s_r;
                    c_out_next_s = c_out_r;
                    ko_next_s    = 1'b0;
                end
            end
            default: begin
                s_next_s     = {(RAIL_NUM*WIDTH){1'b0}};
                c_out_next_s = 2'b00;
                ko_next_s    = 1'b1;
            end
        endcase
    end

    // Output registers, frozen while en is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s_r     <= {(RAIL_NUM*WIDTH){1'b0}};
            c_out_r <= 2'b00;
            ko_r    <= 1'b1;
            err_r   <= 1'b0;
        end else if (en) begin
            s_r     <= s_next_s;
            c_out_r <= c_out_next_s;
            ko_r    <= ko_next_s;
            err_r   <= err_next_s;
        end else begin
            s_r     <= s_r;
            c_out_r <= c_out_r;
            ko_r    <= ko_r;
            err_r   <= err_r;
        end
    end

    assign s     = s_r;
    assign c_out = c_out_r;
    assign ko    = ko_r;
    assign err   = err_r;

endmodule
